// File: rtl/grid_row_tx.sv
// grid_row_tx: snapshots the live Game-of-Life grid on start and streams it out one row per valid/ready beat.
// Optional macro GRID_TX_POPCOUNT_EN adds alive_cnt, the live-cell count of the most recently sent frame.
module grid_row_tx #(
   parameter int unsigned ROWS = 8,
   parameter int unsigned COLS = 8,
   parameter int unsigned RW   = $clog2(ROWS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ROWS*COLS-1:0] grid,
   input  logic                 start,
   output logic                 busy,
   output logic [COLS-1:0]      row_data,
   output logic [RW-1:0]        row_idx,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic                 row_first,
   output logic                 row_last,
   output logic                 frame_done,
   output logic                 overrun
`ifdef GRID_TX_POPCOUNT_EN
   ,
   output logic [$clog2(ROWS*COLS+1)-1:0] alive_cnt
`endif
);

   localparam logic [RW-1:0] LAST_IDX = RW'(ROWS - 1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e                     state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]  snap_q, snap_d;
   logic [ROWS-1:0][COLS-1:0]  grid_rows;
   logic [RW-1:0]              idx_d, idx_nxt;
   logic [COLS-1:0]            data_d;
   logic                       valid_d, first_d, last_d, busy_d, done_d, overrun_d;

   assign grid_rows = grid;
   assign idx_nxt   = row_idx + RW'(1);

`ifdef GRID_TX_POPCOUNT_EN
   localparam int unsigned CW = $clog2(ROWS*COLS+1);

   logic [CW-1:0] acc_q, acc_d, alive_d;

   function automatic logic [CW-1:0] popcount(input logic [COLS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < int'(COLS); i++) n = n + CW'(v[i]);
      return n;
   endfunction
`endif

   // Next-state and next-output logic; every output is registered from these.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      idx_d     = row_idx;
      data_d    = row_data;
      valid_d   = row_valid;
      first_d   = row_first;
      last_d    = row_last;
      busy_d    = busy;
      done_d    = 1'b0;
      overrun_d = overrun;
`ifdef GRID_TX_POPCOUNT_EN
      acc_d     = acc_q;
      alive_d   = alive_cnt;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SEND;
               snap_d    = grid_rows;
               idx_d     = '0;
               data_d    = grid_rows[0];
               valid_d   = 1'b1;
               first_d   = 1'b1;
               last_d    = (ROWS == 1);
               busy_d    = 1'b1;
               overrun_d = 1'b0;
`ifdef GRID_TX_POPCOUNT_EN
               acc_d     = '0;
`endif
            end
         end
         SEND: begin
            if (start) overrun_d = 1'b1;
            if (row_valid && row_ready) begin
`ifdef GRID_TX_POPCOUNT_EN
               acc_d = acc_q + popcount(row_data);
`endif
               if (row_last) begin
                  // Frame complete: drop back to IDLE with a clean beat bus.
                  state_d = IDLE;
                  idx_d   = '0;
                  data_d  = '0;
                  valid_d = 1'b0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`ifdef GRID_TX_POPCOUNT_EN
                  alive_d = acc_d;
`endif
               end else begin
                  idx_d   = idx_nxt;
                  data_d  = snap_q[idx_nxt];
                  first_d = 1'b0;
                  last_d  = (idx_nxt == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         row_idx    <= '0;
         row_data   <= '0;
         row_valid  <= 1'b0;
         row_first  <= 1'b0;
         row_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         row_idx    <= idx_d;
         row_data   <= data_d;
         row_valid  <= valid_d;
         row_first  <= first_d;
         row_last   <= last_d;
         busy       <= busy_d;
         frame_done <= done_d;
         overrun    <= overrun_d;
      end
   end

`ifdef GRID_TX_POPCOUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         alive_cnt <= '0;
      end else begin
         acc_q     <= acc_d;
         alive_cnt <= alive_d;
      end
   end
`endif

endmodule

// File: doc/grid_row_tx.md
Name: grid_row_tx

Overview:
Readout end of the Game-of-Life grid interface: snapshots the 64-bit evolving grid driven by CONTROL and streams it out one row per beat over a valid/ready handshake. It feeds display drivers or a host dump path. It replaces bench-side `$fdisplay` of `register_v[8r+7:8r]` with a synthesizable reader. Row r of the grid is bits [r*COLS +: COLS]; row 0 is sent first.

Parameters:
- ROWS, 8, number of grid rows per frame.
- COLS, 8, cells per row; grid width is ROWS*COLS.
- RW, $clog2(ROWS), width of row index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- grid  input  ROWS*COLS  live grid from CONTROL (`register_v`).
- start  input  1  request to snapshot `grid` and send one frame.
- busy  output  1  frame in progress.
- row_data  output  COLS  current row payload.
- row_idx  output  RW  index of current row.
- row_valid  output  1  row_data/row_idx valid.
- row_ready  input  1  sink accepts the row.
- row_first  output  1  high with row_idx==0 beat.
- row_last  output  1  high with row_idx==ROWS-1 beat.
- frame_done  output  1  one-cycle pulse after last row accepted.
- overrun  output  1  sticky: a start was dropped while busy.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - busy=0, row_valid=0, row_data=0, row_idx=0.
  - row_first=0, row_last=0, frame_done=0, overrun=0.
  - Snapshot register=0.
- FSM states: IDLE, SEND.
- IDLE + start:
  - Latch snapshot<=grid on that edge; go to SEND.
  - Next cycle: row_valid=1, row_idx=0, row_first=1, busy=1.
  - Latency is 1 cycle from start to first valid.
- SEND:
  - row_data = snapshot[row_idx*COLS +: COLS].
  - A beat transfers on a cycle with row_valid && row_ready.
  - Before transfer: row_data, row_idx, row_first and row_last are held stable.
  - After a non-last transfer: row_idx increments; row_valid stays 1, so back-to-back beats run at 1 row/cycle.
  - After the last transfer (row_idx==ROWS-1): row_valid=0, busy=0, frame_done=1 for exactly one cycle, state=IDLE.
- Grid changes during SEND do not affect the frame; the snapshot is fixed until the next accepted start.
- Minimum frame: ROWS+1 cycles from start to frame_done with row_ready tied high.
- start while busy, including the cycle of the last-row transfer:
  - The start is ignored and overrun is set to 1.
  - overrun clears on the next accepted start (the IDLE+start edge).
  - A start in the frame_done cycle is accepted (state is IDLE).
- row_ready while row_valid=0 has no effect.
- Reset asserted mid-frame aborts immediately; no frame_done is issued.
- row_idx wraps to 0 only via return to IDLE, never by counter overflow.

Optional Feature:
- Macro: GRID_TX_POPCOUNT_EN.
- When defined:
  - Extra output `alive_cnt` of width $clog2(ROWS*COLS+1).
  - An accumulator clears on accepted start and adds popcount(row_data) on each transferred beat.
  - alive_cnt is updated with the last beat's sum, valid and stable from the frame_done cycle until the next accepted start.
  - Reset value is 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Basic frame: reset 1→0; grid=64'h0412_6424_0034_3C28; start 1 cycle; row_ready=1.
  - Rows in order: 28, 3C, 34, 00, 24, 64, 12, 04 (hex), row_idx 0..7.
  - row_first only on beat 0, row_last only on beat 7.
  - frame_done exactly 9 cycles after start.
- Backpressure: same frame, row_ready low 3 cycles on beat 2.
  - row_data=8'h34 and row_idx=2 held stable throughout; no skipped or duplicated rows.
- Snapshot isolation: change grid to 64'hFFFF_FFFF_FFFF_FFFF after start.
  - Streamed rows still match the latched 0412_6424_0034_3C28.
- Overrun: pulse start during beat 4 → overrun=1, frame unaffected. Pulse start in the frame_done cycle → accepted, overrun clears, new frame begins.
- Reset mid-frame: assert reset at beat 5.
  - All outputs 0 immediately; no frame_done.
  - After release, a start sends a full fresh frame.
- GRID_TX_POPCOUNT_EN: basic frame → alive_cnt=17 at frame_done. All-ones grid → alive_cnt=64.
